// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding, retry counter width and timer sizing helper for reset_sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } seq_state_e;

  localparam int RETRY_W = 4;

  // One extra bit over clog2 so the larger load value always fits.
  function automatic int timer_width(input int hold_cycles, input int timeout);
    int span;
    span = (hold_cycles > timeout) ? hold_cycles : timeout;
    return $clog2(span) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_ready_sync.sv
// Per-bit two-flop synchroniser for the stage ready acknowledgments.
module ready_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous ready bits
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset chain initiator: releases stage resets in ascending order, retrying on timeout.
// Build option RESET_SEQ_SYNC_READY_EN adds a two-flop synchroniser on ready.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 1000,
  parameter int TIMEOUT     = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  soft_reset,
  input  logic [NUM_STAGES-1:0] ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic [NUM_STAGES-1:0] stage_resetn,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [RETRY_W-1:0]    retry_count
);

  localparam int TIMER_W = timer_width(HOLD_CYCLES, TIMEOUT);
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [TIMER_W-1:0]    HOLD_LOAD    = TIMER_W'(HOLD_CYCLES);
  localparam logic [TIMER_W-1:0]    TIMEOUT_LOAD = TIMER_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]      LAST_IDX     = IDX_W'(NUM_STAGES - 1);
  localparam logic [RETRY_W-1:0]    RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
  localparam logic [NUM_STAGES-1:0] ALL_ONES     = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] FIRST_STAGE  = NUM_STAGES'(1'b1);

  seq_state_e              state_r;
  logic [TIMER_W-1:0]      timer_r;
  logic [IDX_W-1:0]        idx_r;
  logic [RETRY_W-1:0]      retry_r;
  logic [NUM_STAGES-1:0]   stage_reset_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    error_r;
  logic [NUM_STAGES-1:0]   ready_use_s;
  logic [NUM_STAGES-1:0]   ready_prev_r;
  logic [NUM_STAGES-1:0]   next_mask_s;
  logic                    ready_hit_s;
  logic                    fall_s;

`ifdef RESET_SEQ_SYNC_READY_EN
  logic [1:0] settle_r;
  logic       release_s;

  ready_sync #(.WIDTH(NUM_STAGES)) u_ready_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (ready),
    .q      (ready_use_s)
  );

  assign release_s = !soft_reset &&
                     (((state_r == S_HOLD) && (timer_r == '0)) ||
                      ((state_r == S_WAIT) && ready_hit_s && (idx_r != LAST_IDX)));

  // Ignore a just-released stage's ready until its acknowledgment can reach the synchroniser output
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      settle_r <= 2'd0;
    end else if (soft_reset) begin
      settle_r <= 2'd0;
    end else if (release_s) begin
      settle_r <= 2'd2;
    end else if (settle_r != 2'd0) begin
      settle_r <= settle_r - 2'd1;
    end else begin
      settle_r <= settle_r;
    end
  end

  assign ready_hit_s = ready_use_s[idx_r] && (settle_r == 2'd0);
`else
  assign ready_use_s = ready;
  assign ready_hit_s = ready_use_s[idx_r];
`endif

  assign next_mask_s = FIRST_STAGE << (idx_r + IDX_W'(1'b1));
  assign fall_s      = |(ready_prev_r & ~ready_use_s);

  // Previous ready sample for falling-edge detection while DONE
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ready_prev_r <= '0;
    end else begin
      ready_prev_r <= ready_use_s;
    end
  end

  // Sequencer state, timer, stage index, retry count and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r       <= S_HOLD;
      timer_r       <= HOLD_LOAD;
      idx_r         <= '0;
      retry_r       <= '0;
      stage_reset_r <= ALL_ONES;
      busy_r        <= 1'b1;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else if (soft_reset) begin
      state_r       <= S_HOLD;
      timer_r       <= HOLD_LOAD;
      idx_r         <= '0;
      retry_r       <= '0;
      stage_reset_r <= ALL_ONES;
      busy_r        <= 1'b1;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      case (state_r)
        S_HOLD: begin
          if (timer_r == '0) begin
            stage_reset_r <= ALL_ONES & ~FIRST_STAGE;
            idx_r         <= '0;
            timer_r       <= TIMEOUT_LOAD;
            state_r       <= S_WAIT;
          end else begin
            timer_r <= timer_r - TIMER_W'(1'b1);
          end
        end
        S_WAIT: begin
          // A ready arriving on the expiry cycle still counts as success.
          if (ready_hit_s) begin
            if (idx_r == LAST_IDX) begin
              stage_reset_r <= '0;
              state_r       <= S_DONE;
              busy_r        <= 1'b0;
              done_r        <= 1'b1;
            end else begin
              idx_r         <= idx_r + IDX_W'(1'b1);
              stage_reset_r <= stage_reset_r & ~next_mask_s;
              timer_r       <= TIMEOUT_LOAD;
            end
          end else if (timer_r == '0) begin
            stage_reset_r <= ALL_ONES;
            if (retry_r < RETRY_LIMIT) begin
              retry_r <= retry_r + RETRY_W'(1'b1);
              timer_r <= HOLD_LOAD;
              state_r <= S_HOLD;
            end else begin
              state_r <= S_FAULT;
              busy_r  <= 1'b0;
              error_r <= 1'b1;
            end
          end else begin
            timer_r <= timer_r - TIMER_W'(1'b1);
          end
        end
        S_DONE: begin
          if (fall_s) begin
            state_r       <= S_HOLD;
            timer_r       <= HOLD_LOAD;
            idx_r         <= '0;
            retry_r       <= '0;
            stage_reset_r <= ALL_ONES;
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
          end else begin
            stage_reset_r <= '0;
          end
        end
        S_FAULT: begin
          stage_reset_r <= ALL_ONES;
          error_r       <= 1'b1;
        end
        default: begin
          state_r       <= S_HOLD;
          timer_r       <= HOLD_LOAD;
          idx_r         <= '0;
          stage_reset_r <= ALL_ONES;
          busy_r        <= 1'b1;
          done_r        <= 1'b0;
          error_r       <= 1'b0;
        end
      endcase
    end
  end

  assign stage_reset  = stage_reset_r;
  assign stage_resetn = ~stage_reset_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign retry_count  = retry_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (3 stages, hold 10, timeout 20, 2 retries).
module tb_reset_sequencer;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic [2:0] ready;
  logic [2:0] stage_reset;
  logic [2:0] stage_resetn;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] retry_count;

  int check_count = 0;
  int fail_count  = 0;

  reset_sequencer #(
    .NUM_STAGES  (3),
    .HOLD_CYCLES (10),
    .TIMEOUT     (20),
    .MAX_RETRY   (2)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .soft_reset   (soft_reset),
    .ready        (ready),
    .stage_reset  (stage_reset),
    .stage_resetn (stage_resetn),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .retry_count  (retry_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    ready      = 3'b111;
    repeat (5) tick();
    check_value("rst_stage_reset", stage_reset, 3'b111);
    check_value("rst_stage_resetn", stage_resetn, 3'b000);
    check_value("rst_busy", busy, 1'b1);
    check_value("rst_done", done, 1'b0);
    check_value("rst_error", error, 1'b0);
    check_value("rst_retry", retry_count, 4'd0);

    // Normal sequence with all ready tied high
    resetn = 1'b1;
    repeat (10) tick();
    check_value("hold_last", stage_reset, 3'b111);
    tick();
    check_value("rel_stage0", stage_reset, 3'b110);
    check_value("rel_stage0_n", stage_resetn, 3'b001);
    tick();
    check_value("rel_stage1", stage_reset, 3'b100);
    tick();
    check_value("rel_stage2", stage_reset, 3'b000);
    check_value("rel_stage2_done", done, 1'b0);
    tick();
    check_value("done_flag", done, 1'b1);
    check_value("done_busy", busy, 1'b0);

    // One-cycle drop of ready[0] in DONE restarts the sequence
    ready = 3'b110;
    tick();
    ready = 3'b111;
    check_value("drop_stage_reset", stage_reset, 3'b111);
    check_value("drop_busy", busy, 1'b1);
    check_value("drop_done", done, 1'b0);
    check_value("drop_retry", retry_count, 4'd0);
    repeat (10) tick();
    check_value("drop_hold_last", stage_reset, 3'b111);
    tick();
    check_value("drop_rel0", stage_reset, 3'b110);
    tick();
    check_value("drop_rel1", stage_reset, 3'b100);
    tick();
    check_value("drop_rel2", stage_reset, 3'b000);
    tick();
    check_value("drop_done_again", done, 1'b1);

    // ready[1] stuck low: two retries, then FAULT
    ready = 3'b101;
    tick();
    check_value("stuck_restart", stage_reset, 3'b111);
    for (int r = 0; r <= 2; r++) begin
      repeat (10) tick();
      tick();
      check_value("retry_rel0", stage_reset, 3'b110);
      tick();
      check_value("retry_rel1", stage_reset, 3'b100);
      repeat (20) tick();
      check_value("retry_still_waiting", stage_reset, 3'b100);
      tick();
      check_value("retry_stage_reset", stage_reset, 3'b111);
      if (r < 2) begin
        check_value("retry_count", retry_count, 32'(r + 1));
        check_value("retry_busy", busy, 1'b1);
      end else begin
        check_value("fault_error", error, 1'b1);
        check_value("fault_busy", busy, 1'b0);
        check_value("fault_done", done, 1'b0);
      end
    end
    ready = 3'b111;
    repeat (5) tick();
    check_value("fault_sticky_error", error, 1'b1);
    check_value("fault_sticky_stage", stage_reset, 3'b111);

    // soft_reset leaves FAULT; ready[1] then arrives exactly on the expiry cycle
    ready      = 3'b101;
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check_value("soft_error", error, 1'b0);
    check_value("soft_stage", stage_reset, 3'b111);
    check_value("soft_busy", busy, 1'b1);
    check_value("soft_retry", retry_count, 4'd0);
    repeat (10) tick();
    check_value("soft_hold_last", stage_reset, 3'b111);
    tick();
    check_value("soft_rel0", stage_reset, 3'b110);
    tick();
    check_value("soft_rel1", stage_reset, 3'b100);
    repeat (20) tick();
    check_value("edge_before", stage_reset, 3'b100);
    ready = 3'b111;
    tick();
    check_value("edge_ready_wins", stage_reset, 3'b000);
    check_value("edge_no_retry", retry_count, 4'd0);
    tick();
    check_value("edge_done", done, 1'b1);

    // Ready of an unreleased stage is ignored; async reset mid-sequence
    resetn = 1'b0;
    #1;
    check_value("async_stage", stage_reset, 3'b111);
    check_value("async_done", done, 1'b0);
    ready = 3'b110;
    tick();
    resetn = 1'b1;
    repeat (10) tick();
    tick();
    check_value("ign_rel0", stage_reset, 3'b110);
    repeat (3) tick();
    check_value("ign_unreleased", stage_reset, 3'b110);
    ready = 3'b111;
    tick();
    check_value("ign_rel1", stage_reset, 3'b100);
    #2;
    resetn = 1'b0;
    #1;
    check_value("async_mid_stage", stage_reset, 3'b111);
    check_value("async_mid_busy", busy, 1'b1);
    check_value("async_mid_retry", retry_count, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
